// File: rtl/poly_sched_pkg.sv
// Shared definitions for the polynomial-evaluation scheduler: FSM encoding,
// sequencer step count and the default watchdog limit.
package poly_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } sched_state_t;

    localparam int SEQ_STEPS           = 6;
    localparam int DEFAULT_TIMEOUT_CYC = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr
// (wrapping N-1 -> 0) wins; the caller registers the one-hot result.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic          any
);

    localparam int DISTW = PW + 1;

    logic found;

    // Priority distance of requester j from the pointer, modulo N.
    function automatic logic [DISTW-1:0] dist_from_ptr(input logic [PW-1:0] p, input int j);
        logic [DISTW-1:0] d;
        d = DISTW'(j) + DISTW'(N) - {1'b0, p};
        if (d >= DISTW'(N)) begin
            d = d - DISTW'(N);
        end
        return d;
    endfunction

    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req[j] && (dist_from_ptr(ptr, j) == DISTW'(i))) begin
                    win[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/poly_eval_scheduler.sv
// Shares one polynomial-evaluation sequencer among N requesters with round-robin
// arbitration. Define WATCHDOG_EN to abort RUN after TIMEOUT_CYC cycles.
module poly_eval_scheduler
    import poly_sched_pkg::*;
#(
    parameter int N           = 4,
    parameter int DW          = 16,
    parameter int RW          = 32,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] req_data,
    output logic [N-1:0]    grant,
    output logic [DW-1:0]   eval_x,
    output logic            seq_hold,
    input  logic            eval_done,
    input  logic [RW-1:0]   eval_result,
    output logic [N-1:0]    resp_valid,
    output logic [RW-1:0]   resp_data,
    output logic            busy,
    output logic            err_timeout
);

    localparam int PW = $clog2(N);

    sched_state_t  state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [N-1:0]  resp_valid_q, resp_valid_d;
    logic [DW-1:0] eval_x_q, eval_x_d;
    logic [RW-1:0] resp_data_q, resp_data_d;
    logic          seq_hold_q, seq_hold_d;
    logic          err_timeout_q, err_timeout_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] owner_q, owner_d;

    logic [N-1:0]  arb_win;
    logic          arb_any;
    logic [DW-1:0] win_data;
    logic [PW-1:0] win_idx;
    logic          expired;

    rr_arbiter #(.N(N), .PW(PW)) u_arb (
        .req (req),
        .ptr (rr_ptr_q),
        .win (arb_win),
        .any (arb_any)
    );

    always_comb begin
        win_data = '0;
        win_idx  = '0;
        for (int i = 0; i < N; i++) begin
            if (arb_win[i]) begin
                win_data = req_data[i*DW +: DW];
                win_idx  = PW'(i);
            end
        end
    end

`ifdef WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] run_cnt_q, run_cnt_d;

    // Counts completed RUN cycles; LOAD always precedes RUN, so clear there.
    always_comb begin
        run_cnt_d = run_cnt_q;
        if (state_q == LOAD) begin
            run_cnt_d = '0;
        end else if (state_q == RUN) begin
            run_cnt_d = run_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_cnt_q <= '0;
        end else begin
            run_cnt_q <= run_cnt_d;
        end
    end

    assign expired = (run_cnt_q + CW'(1)) == CW'(TIMEOUT_CYC);
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        resp_valid_d  = '0;
        eval_x_d      = eval_x_q;
        resp_data_d   = resp_data_q;
        seq_hold_d    = seq_hold_q;
        err_timeout_d = 1'b0;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        case (state_q)
            IDLE: begin
                seq_hold_d = 1'b1;
                if (arb_any) begin
                    grant_d  = arb_win;
                    eval_x_d = win_data;
                    owner_d  = win_idx;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                seq_hold_d = 1'b0;
                state_d    = RUN;
            end
            RUN: begin
                // A real result in the expiry cycle takes precedence over the abort.
                if (eval_done || expired) begin
                    state_d       = DONE;
                    seq_hold_d    = 1'b1;
                    grant_d       = '0;
                    resp_valid_d  = grant_q;
                    resp_data_d   = eval_done ? eval_result : '0;
                    err_timeout_d = !eval_done;
                end
            end
            DONE: begin
                rr_ptr_d = (owner_q == PW'(N - 1)) ? '0 : owner_q + PW'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            resp_valid_q  <= '0;
            eval_x_q      <= '0;
            resp_data_q   <= '0;
            seq_hold_q    <= 1'b1;
            err_timeout_q <= 1'b0;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            resp_valid_q  <= resp_valid_d;
            eval_x_q      <= eval_x_d;
            resp_data_q   <= resp_data_d;
            seq_hold_q    <= seq_hold_d;
            err_timeout_q <= err_timeout_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
        end
    end

    assign grant       = grant_q;
    assign eval_x      = eval_x_q;
    assign seq_hold    = seq_hold_q;
    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;
    assign err_timeout = err_timeout_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_poly_eval_scheduler.sv
// Self-checking bench for poly_eval_scheduler with a sequencer model and a
// transaction-level reference model; define WATCHDOG_EN to cover the abort path.
`timescale 1ns/1ps
module tb_poly_eval_scheduler;
    import poly_sched_pkg::*;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int RW = 32;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    grant;
    logic [DW-1:0]   eval_x;
    logic            seq_hold;
    logic            eval_done;
    logic [RW-1:0]   eval_result;
    logic [N-1:0]    resp_valid;
    logic [RW-1:0]   resp_data;
    logic            busy;
    logic            err_timeout;

    int n_vectors = 0;
    int n_miscompares = 0;
    int done_mode = 0;
    int seq_step = 0;

    poly_eval_scheduler #(.N(N), .DW(DW), .RW(RW), .TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .grant       (grant),
        .eval_x      (eval_x),
        .seq_hold    (seq_hold),
        .eval_done   (eval_done),
        .eval_result (eval_result),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // p(x) = 1 + 2x + 3x^2 + 4x^3 + 5x^4 + 6x^5, summed term by term.
    function automatic logic [31:0] polyRef(input logic [15:0] x);
        logic [31:0] sum;
        logic [31:0] pw;
        sum = 32'd0;
        pw  = 32'd1;
        for (int k = 0; k < SEQ_STEPS; k++) begin
            sum = sum + 32'(k + 1) * pw;
            pw  = pw * {16'd0, x};
        end
        return sum;
    endfunction

    // Same polynomial as the sequencer's accumulator would produce it.
    function automatic logic [31:0] hornerEval(input logic [15:0] x);
        logic [31:0] acc;
        acc = 32'd0;
        for (int k = SEQ_STEPS; k >= 1; k--) begin
            acc = acc * {16'd0, x} + 32'(k);
        end
        return acc;
    endfunction

    // Sequencer model: ready 7 cycles after clear is released (or as done_mode dictates).
    always @(posedge clk) begin
        if (seq_hold) seq_step <= 0;
        else if (seq_step < 31) seq_step <= seq_step + 1;
    end

    assign eval_done   = (done_mode == 0 && seq_step == SEQ_STEPS + 1) ||
                         (done_mode == 2 && seq_step == TO - 1);
    assign eval_result = eval_done ? hornerEval(eval_x) : 32'hDEAD_BEEF;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [15:0] d0, input logic [15:0] d1,
                                 input logic [15:0] d2, input logic [15:0] d3);
        @(posedge clk);
        #1;
        req      = r;
        req_data = {d3, d2, d1, d0};
    endtask

    task automatic dropReq(input logic [3:0] mask);
        @(posedge clk);
        #1;
        req = req & ~mask;
    endtask

    task automatic waitResp(input logic [3:0] mask, input int budget, output logic [3:0] rv,
                            output logic [31:0] rd, output logic et, output int low);
        rv = '0; rd = '0; et = 1'b0; low = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if ((resp_valid & mask) != 4'd0) begin
                rv = resp_valid;
                rd = resp_data;
                et = err_timeout;
                return;
            end
            if (!seq_hold) low++;
        end
        n_vectors++;
        n_miscompares++;
        $display("[TB] FAIL resp_wait: got no resp_valid, expected one within %0d cycles for mask %0h", budget, mask);
    endtask

    // Reference model: one transaction at a time, tracked as owner / run-age / responding.
    int          m_owner = -1;
    int          m_age = 0;
    int          m_ptr = 0;
    logic        m_resp = 1'b0;
    logic        m_err = 1'b0;
    logic [15:0] m_x = '0;
    logic [31:0] m_rdata = '0;
    logic        p_reset = 1'b1;
    logic [3:0]  p_req = '0;
    logic        p_done = 1'b0;
    logic [15:0] p_data [N];
    int          w;
    int          c;
    logic [3:0]  e_grant;
    logic [3:0]  e_rv;

    always @(negedge clk) begin
        if (reset || p_reset) begin
            m_owner = -1; m_age = 0; m_ptr = 0; m_resp = 1'b0; m_err = 1'b0;
            m_x = '0; m_rdata = '0;
        end else if (m_resp) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_resp  = 1'b0;
            m_err   = 1'b0;
        end else if (m_owner < 0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (w < 0 && p_req[c]) w = c;
            end
            if (w >= 0) begin
                m_owner = w;
                m_age   = 0;
                m_x     = p_data[w];
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (p_done) begin
            m_resp  = 1'b1;
            m_rdata = polyRef(m_x);
        end
`ifdef WATCHDOG_EN
        else if (m_age == TO) begin
            m_resp  = 1'b1;
            m_rdata = '0;
            m_err   = 1'b1;
        end
`endif
        else begin
            m_age++;
        end

        e_grant = (m_owner >= 0 && !m_resp) ? 4'(1 << m_owner) : 4'd0;
        e_rv    = m_resp ? 4'(1 << m_owner) : 4'd0;
        checkOutput("grant", grant, e_grant);
        checkOutput("resp_valid", resp_valid, e_rv);
        checkOutput("seq_hold", seq_hold, !(m_owner >= 0 && !m_resp && m_age >= 1));
        checkOutput("busy", busy, m_owner >= 0);
        checkOutput("eval_x", eval_x, m_x);
        checkOutput("resp_data", resp_data, m_rdata);
        checkOutput("err_timeout", err_timeout, m_resp && m_err);

        p_reset = reset;
        p_req   = req;
        p_done  = eval_done;
        for (int k = 0; k < N; k++) p_data[k] = req_data[k*DW +: DW];
    end

    logic [3:0]  exp_rv [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [31:0] exp_rd [5] = '{32'd21, 32'd321, 32'd2005, 32'd7737, 32'd21};

    task automatic resetDut();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        logic [3:0]  rv;
        logic [31:0] rd;
        logic        et;
        int          low;

        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_grant", grant, 4'b0000);
        checkOutput("rst_seq_hold", seq_hold, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_resp_data", resp_data, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        $display("[TB] single request");
        applyStimulus(4'b0100, 16'd0, 16'd0, 16'h0003, 16'd0);
        @(negedge clk);
        checkOutput("t1_grant_pre", grant, 4'b0000);
        checkOutput("t1_hold_a", seq_hold, 1'b1);
        @(negedge clk);
        checkOutput("t1_grant", grant, 4'b0100);
        checkOutput("t1_hold_b", seq_hold, 1'b1);
        @(negedge clk);
        checkOutput("t1_hold_c", seq_hold, 1'b0);
        waitResp(4'b0100, 30, rv, rd, et, low);
        checkOutput("t1_resp_valid", rv, 4'b0100);
        checkOutput("t1_resp_data", rd, 32'd2005);
        checkOutput("t1_run_len", low, 7);
        dropReq(rv);

        $display("[TB] contention");
        resetDut();
        applyStimulus(4'b1111, 16'd1, 16'd2, 16'd3, 16'd4);
        for (int i = 0; i < 5; i++) begin
            waitResp(4'b1111, 40, rv, rd, et, low);
            checkOutput("t2_order", rv, exp_rv[i]);
            checkOutput("t2_data", rd, exp_rd[i]);
            if (i < 4) begin
                @(negedge clk);
                checkOutput("t2_gap_busy", busy, 1'b0);
            end
        end
        dropReq(4'b1111);

        $display("[TB] pointer wrap");
        applyStimulus(4'b1000, 16'd0, 16'd0, 16'd0, 16'd5);
        waitResp(4'b1000, 30, rv, rd, et, low);
        checkOutput("t3_ch3_alone", rv, 4'b1000);
        checkOutput("t3_ch3_data", rd, 32'd22461);
        dropReq(rv);
        applyStimulus(4'b1001, 16'd7, 16'd0, 16'd0, 16'd5);
        waitResp(4'b1001, 30, rv, rd, et, low);
        checkOutput("t3_first", rv, 4'b0001);
        checkOutput("t3_first_data", rd, 32'd114381);
        dropReq(rv);
        waitResp(4'b1001, 30, rv, rd, et, low);
        checkOutput("t3_second", rv, 4'b1000);
        checkOutput("t3_second_data", rd, 32'd22461);
        dropReq(rv);

        $display("[TB] drop request mid-run");
        applyStimulus(4'b0010, 16'd0, 16'd9, 16'd0, 16'd0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        req = 4'b0000;
        req_data[1*DW +: DW] = 16'h1234;
        waitResp(4'b0010, 30, rv, rd, et, low);
        checkOutput("t4_resp_valid", rv, 4'b0010);
        checkOutput("t4_resp_data", rd, 32'd390277);
        checkOutput("t4_eval_x_held", eval_x, 16'd9);
        @(negedge clk);
        checkOutput("t4_idle_busy", busy, 1'b0);

        $display("[TB] reset mid-run");
        applyStimulus(4'b0100, 16'd0, 16'd0, 16'd3, 16'd0);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checkOutput("t5_grant", grant, 4'b0000);
        checkOutput("t5_seq_hold", seq_hold, 1'b1);
        checkOutput("t5_busy", busy, 1'b0);
        checkOutput("t5_resp_valid", resp_valid, 4'b0000);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        req      = 4'b1101;
        req_data = {16'd4, 16'd3, 16'd0, 16'd11};
        waitResp(4'b1101, 30, rv, rd, et, low);
        checkOutput("t5_first_after_reset", rv, 4'b0001);
        checkOutput("t5_data", rd, 32'd1045221);
        dropReq(4'b1101);

`ifdef WATCHDOG_EN
        $display("[TB] watchdog abort");
        done_mode = 1;
        applyStimulus(4'b0001, 16'd5, 16'd0, 16'd0, 16'd0);
        waitResp(4'b0001, 40, rv, rd, et, low);
        checkOutput("t6_resp_valid", rv, 4'b0001);
        checkOutput("t6_err", et, 1'b1);
        checkOutput("t6_data", rd, 32'd0);
        checkOutput("t6_run_len", low, TO);
        dropReq(rv);

        $display("[TB] watchdog tie goes to eval_done");
        done_mode = 2;
        applyStimulus(4'b0001, 16'd5, 16'd0, 16'd0, 16'd0);
        waitResp(4'b0001, 40, rv, rd, et, low);
        checkOutput("t7_resp_valid", rv, 4'b0001);
        checkOutput("t7_err", et, 1'b0);
        checkOutput("t7_data", rd, 32'd22461);
        checkOutput("t7_run_len", low, TO);
        dropReq(rv);
        done_mode = 0;
`endif

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_time_limit: got no end of test, expected completion");
        $fatal(1, "[TB] time limit exceeded");
    end

endmodule
